// File: rtl/pe_sched_pkg.sv
// Shared types and helpers for the round-robin PE scheduler.
// Field extractors take the instruction zero-extended to 32 bits so they work for any DATA_W.
package pe_sched_pkg;

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, FAULT} sched_state_t;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_op_t;

  function automatic int sel_imm(input int sel_w);
    return (1 << sel_w) - 1;
  endfunction

  // Instruction layout, MSB first: {op0, op1, use_imm0, use_imm1, alu_op}
  function automatic logic [31:0] instr_op0(input logic [31:0] instr, input int data_w);
    return (instr >> (data_w + 4)) & ((32'd1 << data_w) - 32'd1);
  endfunction

  function automatic logic [31:0] instr_op1(input logic [31:0] instr, input int data_w);
    return (instr >> 4) & ((32'd1 << data_w) - 32'd1);
  endfunction

  function automatic logic instr_use_imm0(input logic [31:0] instr);
    return instr[3];
  endfunction

  function automatic logic instr_use_imm1(input logic [31:0] instr);
    return instr[2];
  endfunction

  function automatic alu_op_t instr_alu_op(input logic [31:0] instr);
    return alu_op_t'(instr[1:0]);
  endfunction

endpackage

// File: rtl/pe_operand_check.sv
// Combinational check of one operand: picks the select code and flags a
// reference to a PE that does not exist or has not captured its result yet.
module pe_operand_check
  import pe_sched_pkg::*;
#(
  parameter int NUM_PE = 4,
  parameter int SEL_W  = $clog2(NUM_PE) + 1
) (
  input  logic [SEL_W-1:0]  field,
  input  logic              use_imm,
  input  logic [NUM_PE-1:0] scoreboard,
  output logic [SEL_W-1:0]  sel,
  output logic              fault
);

  localparam int PTR_W = $clog2(NUM_PE);
  localparam logic [SEL_W-1:0] SEL_IMM = SEL_W'(sel_imm(SEL_W));

  always_comb begin
    sel   = field;
    fault = 1'b0;
    if (use_imm) begin
      sel = SEL_IMM;
    end else if (field >= SEL_W'(NUM_PE)) begin
      fault = 1'b1;
    end else if (!scoreboard[field[PTR_W-1:0]]) begin
      fault = 1'b1;
    end
  end

endmodule

// File: rtl/pe_scheduler.sv
// Round-robin PE instruction scheduler with a completion scoreboard and sticky fault.
// Define PE_SCHED_PERF_EN to build the saturating issued/fault performance counters.
module pe_scheduler
  import pe_sched_pkg::*;
#(
  parameter int NUM_PE  = 4,
  parameter int DATA_W  = 4,
  parameter int SEL_W   = $clog2(NUM_PE) + 1,
  parameter int PE_LAT  = 1,
  parameter int INSTR_W = 2 * DATA_W + 4,
  parameter int CTRL_W  = 2 * SEL_W + 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [INSTR_W-1:0]        instr,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic                      fault_clr,
  output logic [NUM_PE-1:0]         pe_en,
  output logic [NUM_PE-1:0]         pe_out_en,
  output logic [CTRL_W-1:0]         ctrl_word,
  output logic [DATA_W-1:0]         imm0,
  output logic [DATA_W-1:0]         imm1,
  output logic [$clog2(NUM_PE)-1:0] sel_pe,
  output logic                      busy,
  output logic                      wave_done,
  output logic                      clear,
  output logic                      instr_fault,
  output logic [15:0]               issued_cnt,
  output logic [15:0]               fault_cnt,
  output sched_state_t              state_dbg
);

  localparam int PTR_W = $clog2(NUM_PE);

  // Handshake: an instruction transfers on a clock edge where instr_valid and
  // instr_ready are both high; instr_ready is high only in IDLE.
  sched_state_t      state, state_nxt;
  logic [INSTR_W-1:0] ir;
  logic [PTR_W-1:0]  pe_ptr;
  logic [NUM_PE-1:0] scoreboard;
  logic [3:0]        lat_cnt;
  logic              fault_q;

  logic [DATA_W-1:0] op0, op1;
  logic [SEL_W-1:0]  sel_op0, sel_op1;
  logic              fault_op0, fault_op1, dec_fault;
  alu_op_t           alu_op;
  logic [NUM_PE-1:0] pe_onehot;
  logic              last_pe;

  assign op0       = DATA_W'(instr_op0(32'(ir), DATA_W));
  assign op1       = DATA_W'(instr_op1(32'(ir), DATA_W));
  assign alu_op    = instr_alu_op(32'(ir));
  assign dec_fault = fault_op0 | fault_op1;
  assign pe_onehot = NUM_PE'(1) << pe_ptr;
  assign last_pe   = (pe_ptr == PTR_W'(NUM_PE - 1));

  pe_operand_check #(.NUM_PE(NUM_PE), .SEL_W(SEL_W)) u_chk0 (
    .field(op0[SEL_W-1:0]), .use_imm(instr_use_imm0(32'(ir))),
    .scoreboard(scoreboard), .sel(sel_op0), .fault(fault_op0)
  );

  pe_operand_check #(.NUM_PE(NUM_PE), .SEL_W(SEL_W)) u_chk1 (
    .field(op1[SEL_W-1:0]), .use_imm(instr_use_imm1(32'(ir))),
    .scoreboard(scoreboard), .sel(sel_op1), .fault(fault_op1)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pe_en     = '0;
    pe_out_en = '0;
    ctrl_word = '0;
    imm0      = '0;
    imm1      = '0;
    clear     = 1'b0;
    wave_done = 1'b0;
    case (state)
      IDLE: if (instr_valid) state_nxt = DECODE;
      DECODE: begin
        ctrl_word = {sel_op0, sel_op1, alu_op};
        imm0      = op0;
        imm1      = op1;
        if (dec_fault) begin
          clear     = 1'b1;
          state_nxt = FAULT;
        end else begin
          pe_en     = pe_onehot;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        ctrl_word = {sel_op0, sel_op1, alu_op};
        imm0      = op0;
        imm1      = op1;
        if (lat_cnt == 4'd0) begin
          pe_out_en = pe_onehot;
          wave_done = last_pe;
          state_nxt = IDLE;
        end
      end
      FAULT: if (fault_clr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ir         <= '0;
      pe_ptr     <= '0;
      scoreboard <= '0;
      lat_cnt    <= '0;
      fault_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (instr_valid) ir <= instr;
        DECODE: begin
          if (dec_fault) fault_q <= 1'b1;
          else           lat_cnt <= 4'(PE_LAT - 1);
        end
        EXEC: begin
          if (lat_cnt == 4'd0) begin
            // A completed wave clears every bit, including the one just captured.
            if (last_pe) scoreboard <= '0;
            else         scoreboard[pe_ptr] <= 1'b1;
            pe_ptr <= pe_ptr + 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        FAULT: begin
          if (fault_clr) begin
            scoreboard <= '0;
            pe_ptr     <= '0;
            fault_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign sel_pe      = pe_ptr;
  assign instr_fault = fault_q;
  assign state_dbg   = state;

`ifdef PE_SCHED_PERF_EN
  logic [15:0] issued_q, faults_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issued_q <= '0;
      faults_q <= '0;
    end else if (state == DECODE) begin
      if (!dec_fault && issued_q != 16'hFFFF) issued_q <= issued_q + 16'd1;
      if (dec_fault && faults_q != 16'hFFFF)  faults_q <= faults_q + 16'd1;
    end
  end

  assign issued_cnt = issued_q;
  assign fault_cnt  = faults_q;
`else
  assign issued_cnt = '0;
  assign fault_cnt  = '0;
`endif

endmodule

// File: tb/tb_pe_scheduler.sv
// Directed self-checking bench for pe_scheduler at default parameters.
module tb_pe_scheduler;
  import pe_sched_pkg::*;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [11:0]  instr = '0;
  logic         instr_valid = 1'b0;
  logic         fault_clr = 1'b0;
  logic         instr_ready, busy, wave_done, clear, instr_fault;
  logic [3:0]   pe_en, pe_out_en, imm0, imm1;
  logic [7:0]   ctrl_word;
  logic [1:0]   sel_pe;
  logic [15:0]  issued_cnt, fault_cnt;
  sched_state_t state_dbg;

  int total = 0;
  int bad = 0;

  pe_scheduler dut (
    .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .fault_clr(fault_clr), .pe_en(pe_en),
    .pe_out_en(pe_out_en), .ctrl_word(ctrl_word), .imm0(imm0), .imm1(imm1),
    .sel_pe(sel_pe), .busy(busy), .wave_done(wave_done), .clear(clear),
    .instr_fault(instr_fault), .issued_cnt(issued_cnt), .fault_cnt(fault_cnt),
    .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 2 time units after each rising edge.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    tick();
  endtask

  task automatic issue(input logic [11:0] v);
    instr = v; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    total++;
    if ({instr_ready, busy, wave_done, clear, instr_fault} !== 5'b10000) begin
      bad++; $display("FAIL reset_flags: got %b want 10000", {instr_ready, busy, wave_done, clear, instr_fault});
    end
    total++;
    if ({pe_en, pe_out_en, ctrl_word, imm0, imm1, sel_pe} !== 26'd0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {pe_en, pe_out_en, ctrl_word, imm0, imm1, sel_pe});
    end
    total++;
    if ({issued_cnt, fault_cnt} !== 32'd0) begin
      bad++; $display("FAIL reset_cnt: got %h want 0", {issued_cnt, fault_cnt});
    end
    @(negedge clock);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_issue_imm();
    instr = 12'h53D; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    total++;
    if (state_dbg !== DECODE) begin
      bad++; $display("FAIL t1_state: got %0d want %0d", state_dbg, DECODE);
    end
    total++;
    if ({pe_en, ctrl_word, imm0, imm1} !== {4'b0001, 8'hFD, 4'd5, 4'd3}) begin
      bad++; $display("FAIL t1_decode: got %h want 1fd53", {pe_en, ctrl_word, imm0, imm1});
    end
    total++;
    if ({instr_ready, busy, pe_out_en} !== 6'b010000) begin
      bad++; $display("FAIL t1_decode_hs: got %b want 010000", {instr_ready, busy, pe_out_en});
    end
    tick();
    total++;
    if ({pe_out_en, pe_en, wave_done} !== 9'b000100000) begin
      bad++; $display("FAIL t1_strobe: got %b want 000100000", {pe_out_en, pe_en, wave_done});
    end
    tick();
    total++;
    if ({sel_pe, instr_ready, pe_out_en} !== 7'b0110000) begin
      bad++; $display("FAIL t1_after: got %b want 0110000", {sel_pe, instr_ready, pe_out_en});
    end
    // op0 reads PE0 (captured), op1 immediate 9, alu_op 2
    instr = 12'h096; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    total++;
    if ({pe_en, ctrl_word, clear} !== {4'b0010, 8'h1E, 1'b0}) begin
      bad++; $display("FAIL t1_dep_decode: got %h want %h", {pe_en, ctrl_word, clear}, {4'b0010, 8'h1E, 1'b0});
    end
    tick();
    total++;
    if (pe_out_en !== 4'b0010) begin
      bad++; $display("FAIL t1_dep_strobe: got %b want 0010", pe_out_en);
    end
    tick();
    total++;
    if (sel_pe !== 2'd2) begin
      bad++; $display("FAIL t1_dep_ptr: got %0d want 2", sel_pe);
    end
  endtask

  task automatic test_fault_dep();
    instr = 12'h031; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    total++;
    if ({clear, pe_en} !== 5'b10000) begin
      bad++; $display("FAIL t2_clear: got %b want 10000", {clear, pe_en});
    end
    tick();
    total++;
    if ({instr_fault, instr_ready, busy, clear, ctrl_word} !== {4'b1010, 8'h00}) begin
      bad++; $display("FAIL t2_fault: got %h want a00", {instr_fault, instr_ready, busy, clear, ctrl_word});
    end
    instr = 12'h53D; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    total++;
    if ({state_dbg, pe_en} !== {FAULT, 4'b0000}) begin
      bad++; $display("FAIL t2_hold: got %h want %h", {state_dbg, pe_en}, {FAULT, 4'b0000});
    end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    total++;
    if ({state_dbg, sel_pe, instr_fault, instr_ready} !== {IDLE, 2'd0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL t2_clr: got %b want %b", {state_dbg, sel_pe, instr_fault, instr_ready}, {IDLE, 2'd0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_fault_self();
    apply_reset();
    instr = 12'h035; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    total++;
    if ({clear, pe_en, ctrl_word} !== {1'b1, 4'b0000, 8'h1D}) begin
      bad++; $display("FAIL t3_self: got %h want %h", {clear, pe_en, ctrl_word}, {1'b1, 4'b0000, 8'h1D});
    end
    tick();
    total++;
    if ({instr_fault, pe_en} !== 5'b10000) begin
      bad++; $display("FAIL t3_fault: got %b want 10000", {instr_fault, pe_en});
    end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    instr = 12'h53D; instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (pe_en !== 4'(1 << i)) begin
        bad++; $display("FAIL t4_pe_en%0d: got %b want %b", i, pe_en, 4'(1 << i));
      end
      tick();
      total++;
      if ({pe_out_en, wave_done} !== {4'(1 << i), (i == 3)}) begin
        bad++; $display("FAIL t4_out%0d: got %b want %b", i, {pe_out_en, wave_done}, {4'(1 << i), (i == 3)});
      end
      tick();
      if (i == 3) instr_valid = 1'b0;
      total++;
      if (sel_pe !== 2'((i + 1) % 4)) begin
        bad++; $display("FAIL t4_ptr%0d: got %0d want %0d", i, sel_pe, (i + 1) % 4);
      end
    end
    // PE1 was captured during the wave; the wave end must have cleared it
    instr = 12'h105; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    total++;
    if ({clear, pe_en} !== 5'b10000) begin
      bad++; $display("FAIL t4_sb_clear: got %b want 10000", {clear, pe_en});
    end
    tick();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
  endtask

  task automatic test_hold_during_exec();
    instr = 12'h53D; instr_valid = 1'b1;
    tick();
    instr = 12'h0AE;
    total++;
    if ({imm0, imm1, ctrl_word} !== {4'd5, 4'd3, 8'hFD}) begin
      bad++; $display("FAIL t5_dec_ir: got %h want 53fd", {imm0, imm1, ctrl_word});
    end
    tick();
    total++;
    if ({instr_ready, imm0, imm1, ctrl_word, pe_out_en} !== {1'b0, 4'd5, 4'd3, 8'hFD, 4'b0001}) begin
      bad++; $display("FAIL t5_exec_ir: got %h want %h", {instr_ready, imm0, imm1, ctrl_word, pe_out_en}, {1'b0, 4'd5, 4'd3, 8'hFD, 4'b0001});
    end
    tick();
    instr_valid = 1'b0;
    total++;
    if ({instr_ready, sel_pe} !== 3'b101) begin
      bad++; $display("FAIL t5_idle: got %b want 101", {instr_ready, sel_pe});
    end
    // fault_clr outside FAULT has no effect
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    total++;
    if ({state_dbg, sel_pe} !== {IDLE, 2'd1}) begin
      bad++; $display("FAIL t5_clr_ignored: got %b want %b", {state_dbg, sel_pe}, {IDLE, 2'd1});
    end
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    total++;
    if ({pe_en, ctrl_word, imm0, imm1} !== {4'b0010, 8'hFE, 4'd0, 4'hA}) begin
      bad++; $display("FAIL t5_second: got %h want 2fe0a", {pe_en, ctrl_word, imm0, imm1});
    end
    tick();
    tick();
  endtask

  task automatic test_reset_in_exec();
    apply_reset();
    instr = 12'h53D; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    total++;
    if ({instr_ready, busy, pe_en, pe_out_en, ctrl_word, sel_pe, state_dbg} !== {1'b1, 1'b0, 4'b0, 4'b0, 8'h00, 2'd0, IDLE}) begin
      bad++; $display("FAIL t6_async: got %h want %h", {instr_ready, busy, pe_en, pe_out_en, ctrl_word, sel_pe, state_dbg}, {1'b1, 1'b0, 4'b0, 4'b0, 8'h00, 2'd0, IDLE});
    end
    @(posedge clock);
    #1;
    total++;
    if ({pe_out_en, sel_pe} !== 6'd0) begin
      bad++; $display("FAIL t6_no_strobe: got %b want 000000", {pe_out_en, sel_pe});
    end
    @(negedge clock);
    reset = 1'b0;
    tick();
    total++;
    if ({issued_cnt, fault_cnt} !== 32'd0) begin
      bad++; $display("FAIL t6_cnt_reset: got %h want 0", {issued_cnt, fault_cnt});
    end
    issue(12'h53D);
    issue(12'h53D);
    instr = 12'h305; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    total++;
`ifdef PE_SCHED_PERF_EN
    if ({issued_cnt, fault_cnt} !== {16'd2, 16'd1}) begin
      bad++; $display("FAIL t6_perf: got %h want 00020001", {issued_cnt, fault_cnt});
    end
`else
    if ({issued_cnt, fault_cnt} !== 32'd0) begin
      bad++; $display("FAIL t6_perf_off: got %h want 0", {issued_cnt, fault_cnt});
    end
`endif
  endtask

  initial begin
    test_reset();
    test_issue_imm();
    test_fault_dep();
    test_fault_self();
    test_back_to_back();
    test_hold_during_exec();
    test_reset_in_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_scheduler.md
Name: pe_scheduler

Overview:
Parametrised successor to the fixed 4-PE scheduler in the PE-array processor. It accepts instructions over a valid/ready handshake and issues each one to the next PE in round-robin order. It checks operand dependencies against a completion scoreboard, waits a configurable PE latency, then strobes that PE's output register. It reports per-wave completion and a sticky fault.

Parameters:
NUM_PE, 4, number of PEs; power of 2, 2..8
DATA_W, 4, immediate and PE data width; must be at least SEL_W
SEL_W, $clog2(NUM_PE)+1, operand-select width; the all-ones value SEL_IMM selects the immediate
PE_LAT, 1, cycles from PE enable to output capture; 1..15
INSTR_W, 2*DATA_W+4, instruction width (12 at defaults)
CTRL_W, 2*SEL_W+2, PE control word width (8 at defaults)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
instr  in  INSTR_W  fields, MSB first: {op0[DATA_W], op1[DATA_W], use_imm0, use_imm1, alu_op[2]}
instr_valid  in  1  instruction offered
instr_ready  out  1  scheduler can accept an instruction
fault_clr  in  1  acknowledges a fault and restarts the wave
pe_en  out  NUM_PE  one-hot PE enable
pe_out_en  out  NUM_PE  one-hot PE output-register enable
ctrl_word  out  CTRL_W  {sel_op0, sel_op1, alu_op}, broadcast to all PEs
imm0, imm1  out  DATA_W  immediate operands
sel_pe  out  $clog2(NUM_PE)  current PE pointer
busy  out  1  high when state is not IDLE
wave_done  out  1  one-cycle pulse when PE NUM_PE-1 output is captured
clear  out  1  one-cycle pulse on fault detection
instr_fault  out  1  sticky fault flag
issued_cnt, fault_cnt  out  16  performance counters (see Optional Feature)

Behaviour:
- Reset: state IDLE; IR=0; pe_ptr=0; scoreboard=0; lat_cnt=0; instr_fault=0; all counters 0.
- Reset-time outputs: instr_ready=1; every other output 0.
- Reset mid-operation aborts the operation at once; no PE strobe completes.
- State IDLE:
  - instr_ready=1.
  - When instr_valid=1: IR<=instr, next state DECODE.
- State DECODE (1 cycle), operand rules:
  - use_immK=1: sel_opK=SEL_IMM.
  - use_immK=0: idx = opK[SEL_W-1:0]. Fault if idx>=NUM_PE or scoreboard[idx]=0.
  - A PE's own index counts as not ready (scoreboard[pe_ptr] is always 0 before capture).
- DECODE on fault: clear=1 this cycle, no pe_en, next state FAULT.
- DECODE without fault: pe_en[pe_ptr]=1 this cycle, lat_cnt<=PE_LAT-1, next state EXEC.
- DECODE/EXEC drive:
  - ctrl_word = {sel_op0, sel_op1, alu_op}.
  - imm0 = op0, imm1 = op1.
  - In any other state, ctrl_word=0, imm0=0, imm1=0.
- State EXEC:
  - lat_cnt decrements each cycle.
  - In the cycle lat_cnt==0: pe_out_en[pe_ptr]=1.
  - On that edge: scoreboard[pe_ptr]<=1, pe_ptr<=pe_ptr+1 (wraps), next state IDLE.
- End of wave (pe_ptr==NUM_PE-1 at capture):
  - wave_done=1 in that same cycle.
  - scoreboard<=0 on that edge (the clear wins over the set).
  - pe_ptr wraps to 0.
- Latency from instruction acceptance to the pe_out_en strobe is PE_LAT+1 cycles.
- Throughput is one instruction per PE_LAT+2 cycles.
- State FAULT:
  - instr_fault=1, instr_ready=0.
  - fault_clr=1: scoreboard<=0, pe_ptr<=0, instr_fault<=0, next state IDLE.
- fault_clr in any state other than FAULT is ignored.
- instr_valid is ignored whenever instr_ready=0; IR holds its value.

Optional Feature:
PE_SCHED_PERF_EN
- Defined:
  - issued_cnt increments on each DECODE without fault.
  - fault_cnt increments on each entry to FAULT.
  - Both saturate at 0xFFFF and clear on reset only.
- Undefined: both ports tied to 0 and no counter flops are generated.

Decomposition:
- Package pe_sched_pkg:
  - state enum sched_state_t {IDLE, DECODE, EXEC, FAULT}
  - alu_op_t (2-bit)
  - SEL_IMM computation function
  - instruction field-extraction functions
- Sub-module pe_operand_check: combinational per-operand check.
  - Inputs: field, use_imm, scoreboard.
  - Outputs: sel, fault.
  - Instantiated twice.

Test Plan:
All scenarios use default parameters.
1. Reset, then instr=0x53D, valid for 1 cycle.
   -> DECODE: pe_en=0001, ctrl_word=0xFD, imm0=5, imm1=3.
   -> Next cycle: pe_out_en=0001; then sel_pe=1, scoreboard=0001.
2. Issue 0x53D to PE0, then instr=0x031 (op0 from PE0, op1 from PE3).
   -> Fault: clear pulse, instr_fault=1, instr_ready=0.
   -> fault_clr -> IDLE, pe_ptr=0.
3. After reset, instr=0x035 (op0 references PE0 at pe_ptr=0).
   -> Fault (self/unfinished reference); no pe_en asserted.
4. Four back-to-back immediate instructions.
   -> pe_en sequence 0001, 0010, 0100, 1000.
   -> wave_done pulses with pe_out_en=1000; then scoreboard=0, sel_pe=0.
5. instr_valid held high during EXEC with a different instr value.
   -> Instruction ignored (instr_ready=0); IR unchanged; accepted only on return to IDLE.
6. Assert reset while in EXEC.
   -> All outputs return to reset values immediately; pe_out_en never strobes.
   -> With PE_SCHED_PERF_EN defined: after two issues and one fault, issued_cnt=2 and fault_cnt=1.
